// File: rtl/rng_prefetch_fifo.sv
// rtl/rng_prefetch_fifo.sv - prefetches RNG words into a FIFO served over iomem with zero wait states
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   iomem_*           CPU register window at BASE_ADDR..BASE_ADDR+0xF (CTRL, STATUS, DATA, COUNT)
//   rng_re/rng_do/
//   rng_wait          exclusive read port of the RNG; a word is taken when re=1 and wait=0
//   fifo_level        current FIFO occupancy (0..DEPTH)

module rng_prefetch_fifo #(
   parameter logic [31:0] BASE_ADDR  = 32'h0300_3000,
   parameter int          DEPTH_LOG2 = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [3:0]          iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [31:0]         iomem_wdata,
   output logic [31:0]         iomem_rdata,
   output logic                rng_re,
   input  logic [31:0]         rng_do,
   input  logic                rng_wait,
   output logic [DEPTH_LOG2:0] fifo_level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [LW-1:0]         LVL_ONE = LW'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

   state_t                state_q, state_d;
   logic                  rng_re_q, rng_re_d;
   logic                  ready_q, ready_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  en_q, en_d;
   logic                  uf_q, uf_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           mem_q [DEPTH];

   logic        sel, access, is_rd, is_wr, clr;
   logic        empty, full, push, push_eff, pop_req, pop;
   logic [1:0]  reg_idx;
   logic [31:0] status_word;
   logic        unused_bits;

   assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:11], iomem_wdata[9:2]};

   always_comb begin
      sel      = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
      // The !ready_q term keeps a still-held valid from being taken as a second access.
      access   = sel && !ready_q;
      is_rd    = access && (iomem_wstrb == 4'b0000);
      is_wr    = access && (iomem_wstrb != 4'b0000);
      reg_idx  = iomem_addr[3:2];
      empty    = (level_q == '0);
      // Level never exceeds DEPTH, so its MSB alone marks full.
      full     = level_q[DEPTH_LOG2];
      clr      = is_wr && (reg_idx == 2'd0) && iomem_wstrb[0] && iomem_wdata[1];
      push     = (state_q == S_REQ) && !rng_wait;
      // A word accepted on the CLR edge is dropped; the RNG still counts it as delivered.
      push_eff = push && !clr;
      pop_req  = is_rd && (reg_idx == 2'd2);
      pop      = pop_req && !empty;
      status_word = 32'(level_q) | {21'b0, uf_q, full, empty, 8'b0};

      ready_d  = access;
      rdata_d  = '0;
      en_d     = en_q;
      uf_d     = uf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      count_d  = count_q;
      state_d  = state_q;

      if (is_rd) begin
         case (reg_idx)
            2'd0:    rdata_d = {31'b0, en_q};
            2'd1:    rdata_d = status_word;
            2'd2:    rdata_d = empty ? 32'hFFFF_FFFF : mem_q[rd_ptr_q];
            default: rdata_d = count_q;
         endcase
      end

      if (is_wr && (reg_idx == 2'd0) && iomem_wstrb[0]) en_d = iomem_wdata[0];
      if (pop_req && empty) uf_d = 1'b1;
      if (is_wr && (reg_idx == 2'd1) && iomem_wstrb[1] && iomem_wdata[10]) uf_d = 1'b0;

      if (clr) begin
         uf_d     = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         count_d  = '0;
      end else begin
         if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + 32'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_eff, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end

      // REQ is left only through an accept, so EN dropping mid-request still completes it.
      case (state_q)
         S_IDLE:  if (en_q && !full && !clr) state_d = S_REQ;
         S_REQ:   if (!rng_wait) state_d = S_GAP;
         default: state_d = S_IDLE;
      endcase
      rng_re_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rng_re_q <= 1'b0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         en_q     <= 1'b0;
         uf_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rng_re_q <= rng_re_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         en_q     <= en_d;
         uf_q     <= uf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff && !reset) mem_q[wr_ptr_q] <= rng_do;
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign rng_re      = rng_re_q;
   assign fifo_level  = level_q;

endmodule

// File: tb/tb_rng_prefetch_fifo.sv
// tb/tb_rng_prefetch_fifo.sv - randomized self-checking bench for rng_prefetch_fifo
// Ports: none (drives clk/reset, an iomem master and an RNG model; compares against a queue model)

module tb_rng_prefetch_fifo;

   localparam logic [31:0] BASE = 32'h0300_3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iomem_valid = 1'b0;
   logic [3:0]  iomem_wstrb = 4'b0;
   logic [31:0] iomem_addr = 32'b0;
   logic [31:0] iomem_wdata = 32'b0;
   logic        iomem_ready;
   logic [31:0] iomem_rdata;
   logic        rng_re;
   logic [31:0] rng_do;
   logic        rng_wait = 1'b0;
   logic [3:0]  fifo_level;

   // Reference model state
   logic [31:0] q[$];
   logic        m_en = 1'b0, m_uf = 1'b0, m_ready = 1'b0;
   logic [31:0] m_rdata = 32'b0, m_cnt = 32'b0, rng_n = 32'b0, last_disc = 32'b0;
   int          wait_budget = 0;
   bit          rand_wait = 1'b0;
   int          stall_cnt = 0, re_drop = 0, gap_viol = 0, ovf = 0, push_pop = 0, clr_hit = 0;
   int          total = 0, bad = 0;

   assign rng_do = 32'h1000_0000 + rng_n;

   always #5 clk = ~clk;

   rng_prefetch_fifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(3)) dut (
      .clk(clk), .reset(reset),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .rng_re(rng_re), .rng_do(rng_do), .rng_wait(rng_wait), .fifo_level(fifo_level)
   );

   // One clock: capture inputs before the edge, then update the model after it.
   task automatic tick();
      logic pv, preset, pre_re, pre_wait, acc, accept, rd, wr, clr, popped;
      logic [31:0] paddr, pwdata, word;
      logic [3:0] pwstrb;
      pv = iomem_valid; paddr = iomem_addr; pwdata = iomem_wdata; pwstrb = iomem_wstrb;
      preset = reset; pre_re = rng_re; pre_wait = rng_wait;
      @(posedge clk);
      @(negedge clk);
      accept = pre_re && !pre_wait;
      word = 32'h1000_0000 + rng_n;
      if (accept) rng_n = rng_n + 1;
      acc = pv && (paddr[31:4] == BASE[31:4]) && !m_ready;
      if (preset) begin
         m_ready = 1'b0; m_rdata = 32'b0; q.delete(); m_en = 1'b0; m_uf = 1'b0; m_cnt = 32'b0;
      end else begin
         rd = acc && (pwstrb == 4'b0);
         wr = acc && (pwstrb != 4'b0);
         clr = wr && (paddr[3:2] == 2'd0) && pwstrb[0] && pwdata[1];
         m_ready = acc; m_rdata = 32'b0; popped = 1'b0;
         if (rd) begin
            case (paddr[3:2])
               2'd0: m_rdata = {31'b0, m_en};
               2'd1: m_rdata = {21'b0, m_uf, q.size() == 8, q.size() == 0, 8'(q.size())};
               2'd2: if (q.size() == 0) begin m_rdata = 32'hFFFF_FFFF; m_uf = 1'b1; end
                     else begin m_rdata = q.pop_front(); popped = 1'b1; end
               default: m_rdata = m_cnt;
            endcase
         end
         if (wr && paddr[3:2] == 2'd0 && pwstrb[0]) m_en = pwdata[0];
         if (wr && paddr[3:2] == 2'd1 && pwstrb[1] && pwdata[10]) m_uf = 1'b0;
         if (clr) begin
            q.delete(); m_cnt = 32'b0; m_uf = 1'b0;
            if (accept) begin clr_hit++; last_disc = word; end
         end else if (accept) begin
            if (q.size() >= 8) ovf++;
            q.push_back(word); m_cnt = m_cnt + 1;
            if (popped) push_pop++;
         end
         if (accept && rng_re) gap_viol++;
         if (pre_re && pre_wait) begin stall_cnt++; if (!rng_re) re_drop++; end
      end
      if (rng_re && wait_budget > 0) begin rng_wait = 1'b1; wait_budget--; end
      else if (rng_re && rand_wait) rng_wait = ($urandom_range(0, 2) == 0);
      else rng_wait = 1'b0;
   endtask

   task automatic bus(input logic [31:0] off, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rdy, output logic rdy2,
                      output logic [31:0] ex);
      iomem_valid = 1'b1; iomem_addr = BASE + off; iomem_wstrb = strb; iomem_wdata = wd;
      tick();
      rd = iomem_rdata; rdy = iomem_ready; ex = m_rdata;
      iomem_valid = 1'b0; iomem_wstrb = 4'b0;
      tick();
      rdy2 = iomem_ready;
   endtask

   task automatic test_reset();
      logic [31:0] rd, ex; logic rdy, rdy2;
      reset = 1'b1; repeat (3) tick(); reset = 1'b0;
      total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", iomem_ready); end
      total++; if (iomem_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", iomem_rdata); end
      total++; if (rng_re !== 1'b0) begin bad++; $display("FAIL rst_re: got %b want 0", rng_re); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      bus(32'h0, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_ctrl: got %h want 0", rd); end
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h100) begin bad++; $display("FAIL rst_status: got %h want 100", rd); end
      bus(32'hC, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_count: got %h want 0", rd); end
   endtask

   task automatic test_fill();
      logic [31:0] rd, ex; logic rdy, rdy2; int g, re_hi;
      bus(32'h0, 4'b0001, 32'h1, rd, rdy, rdy2, ex);
      g = 0;
      while (fifo_level !== 4'd8 && g < 40) begin tick(); g++; end
      total++; if (g + 2 > 28) begin bad++; $display("FAIL fill_time: got %0d cycles want <=28", g + 2); end
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h208 || rd !== ex) begin bad++; $display("FAIL fill_status: got %h want 208", rd); end
      bus(32'hC, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h8) begin bad++; $display("FAIL fill_count: got %h want 8", rd); end
      re_hi = 0;
      repeat (10) begin tick(); if (rng_re !== 1'b0) re_hi++; end
      total++; if (re_hi != 0) begin bad++; $display("FAIL full_re_idle: got %0d want 0", re_hi); end
   endtask

   task automatic test_drain();
      logic [31:0] rd, ex; logic rdy, rdy2;
      bus(32'h0, 4'b0001, 32'h0, rd, rdy, rdy2, ex);
      for (int i = 0; i < 8; i++) begin
         bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
         total++; if (rdy !== 1'b1 || rdy2 !== 1'b0) begin bad++; $display("FAIL drain_ready%0d: got %b%b want 10", i, rdy, rdy2); end
         total++; if (rd !== 32'h1000_0000 + 32'(i) || rd !== ex) begin bad++; $display("FAIL drain_data%0d: got %h want %h", i, rd, 32'h1000_0000 + 32'(i)); end
      end
      bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL underflow_data: got %h want ffffffff", rd); end
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h500 || rd !== ex) begin bad++; $display("FAIL underflow_flag: got %h want 500", rd); end
      bus(32'h4, 4'b0001, 32'h400, rd, rdy, rdy2, ex);
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h500) begin bad++; $display("FAIL w1c_wrong_strb: got %h want 500", rd); end
      bus(32'h4, 4'b0010, 32'h400, rd, rdy, rdy2, ex);
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h100) begin bad++; $display("FAIL w1c_clear: got %h want 100", rd); end
   endtask

   task automatic test_wait();
      logic [31:0] rd, ex; logic rdy, rdy2; int g;
      stall_cnt = 0; re_drop = 0; gap_viol = 0; wait_budget = 5;
      bus(32'h0, 4'b0001, 32'h1, rd, rdy, rdy2, ex);
      g = 0;
      while (q.size() == 0 && g < 30) begin tick(); g++; end
      total++; if (fifo_level !== 4'd1 || q.size() != 1) begin bad++; $display("FAIL wait_one_push: got %0d want 1", fifo_level); end
      total++; if (stall_cnt != 5) begin bad++; $display("FAIL wait_stall: got %0d want 5", stall_cnt); end
      total++; if (re_drop != 0) begin bad++; $display("FAIL wait_re_held: got %0d drops want 0", re_drop); end
      total++; if (rng_re !== 1'b0) begin bad++; $display("FAIL wait_gap: got %b want 0", rng_re); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, ex; logic rdy, rdy2; int g, op;
      rand_wait = 1'b0; gap_viol = 0; re_drop = 0; ovf = 0; push_pop = 0;
      g = 0;
      while (fifo_level !== 4'd8 && g < 40) begin tick(); g++; end
      total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL b2b_full: got %0d want 8", fifo_level); end
      for (int i = 0; i < 2; i++) begin
         bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
         total++; if (rd !== ex) begin bad++; $display("FAIL b2b_pop%0d: got %h want %h", i, rd, ex); end
      end
      total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL b2b_level_const: got %0d want 7", fifo_level); end
      total++; if (push_pop == 0) begin bad++; $display("FAIL b2b_coincide: got %0d want >0", push_pop); end
      rand_wait = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         op = $urandom_range(0, 9);
         if (op < 7)       bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
         else if (op == 7) bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
         else if (op == 8) bus(32'hC, 4'b0, 32'h0, rd, rdy, rdy2, ex);
         else              bus(32'h8, 4'hF, $urandom, rd, rdy, rdy2, ex);
         total++; if (rdy !== 1'b1 || rd !== ex) begin bad++; $display("FAIL rand_op%0d: got %h rdy %b want %h", i, rd, rdy, ex); end
         total++; if (fifo_level !== 4'(q.size())) begin bad++; $display("FAIL rand_level%0d: got %0d want %0d", i, fifo_level, q.size()); end
      end
      rand_wait = 1'b0;
      g = 0;
      while (fifo_level !== 4'd8 && g < 60) begin tick(); g++; end
      total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL refill: got %0d want 8", fifo_level); end
      total++; if (ovf != 0 || gap_viol != 0 || re_drop != 0) begin bad++; $display("FAIL protocol: got ovf=%0d gap=%0d drop=%0d want 0", ovf, gap_viol, re_drop); end
   endtask

   task automatic test_clr_in_req();
      logic [31:0] rd, ex; logic rdy, rdy2; int g;
      clr_hit = 0;
      repeat (2) bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      g = 0;
      while (!(rng_re === 1'b1 && rng_wait === 1'b0) && g < 20) begin tick(); g++; end
      bus(32'h0, 4'b0001, 32'h2, rd, rdy, rdy2, ex);
      total++; if (clr_hit != 1) begin bad++; $display("FAIL clr_in_req: got %0d want 1", clr_hit); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL clr_level: got %0d want 0", fifo_level); end
      bus(32'hC, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_count: got %h want 0", rd); end
      bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL clr_empty: got %h want ffffffff", rd); end
      bus(32'h0, 4'b0001, 32'h1, rd, rdy, rdy2, ex);
      g = 0;
      while (fifo_level === 4'd0 && g < 20) begin tick(); g++; end
      bus(32'h8, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== ex || rd === last_disc) begin bad++; $display("FAIL clr_discard: got %h want %h", rd, ex); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, ex; logic rdy, rdy2; int seen;
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h8; iomem_wstrb = 4'b0; reset = 1'b1;
      tick();
      iomem_valid = 1'b0; reset = 1'b0;
      total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", iomem_ready); end
      tick();
      total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready2: got %b want 0", iomem_ready); end
      total++; if (rng_re !== 1'b0 || fifo_level !== 4'd0 || iomem_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_outs: got re=%b lvl=%0d rdata=%h want 0", rng_re, fifo_level, iomem_rdata); end
      bus(32'h0, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_ctrl: got %h want 0", rd); end
      bus(32'h4, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h100) begin bad++; $display("FAIL rstmid_status: got %h want 100", rd); end
      bus(32'hC, 4'b0, 32'h0, rd, rdy, rdy2, ex);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_count: got %h want 0", rd); end
      iomem_valid = 1'b1; iomem_addr = BASE + 32'h10; iomem_wstrb = 4'b0;
      seen = 0;
      repeat (4) begin tick(); if (iomem_ready !== 1'b0) seen++; end
      iomem_valid = 1'b0;
      total++; if (seen != 0) begin bad++; $display("FAIL out_of_window: got %0d ready cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wait();
      test_back_to_back();
      test_clr_in_req();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
